mul_arbiter: RTL
================

# mul_arbiter

Sequential controller that shares one instance of the 3-bit sign-magnitude multiplier datapath between NUM_REQ requesters. It arbitrates requests round-robin, registers the winning operands, and sequences the multiplier through a fixed three-state FSM. It returns each result to the requester that issued it over a valid/ready response channel. It sits between the ALU's operation decoders and the shared `mul` datapath, so multiply is not replicated per requester.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
- req_a  in  3*NUM_REQ  operand A per requester, slice i = [3i+2:3i]; bit 2 sign, bits 1:0 magnitude
- req_b  in  3*NUM_REQ  operand B per requester, same packing
- rsp_valid  out  NUM_REQ  per-requester result valid (one-hot or zero)
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_data  out  5  result: bit 4 sign = a[2]^b[2], bits 3:0 = a[1:0]*b[1:0] (0..9)
- busy  out  1  high in any state other than IDLE
- op_count  out  8  completed-response counter, wraps 255->0

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Arbiter scans req_valid from pointer ptr upward, modulo NUM_REQ, and grants the first set bit.
  - req_ready is driven combinationally, one-hot on the granted index.
  - On the handshake (valid & ready):
    - latch op_a, op_b and gnt_idx;
    - move to CALC.
  - With no valid request, remain in IDLE with req_ready = 0.
- CALC:
  - Registered operands drive `mul`.
  - Its output is registered into res_q.
  - Move to RESP unconditionally.
- RESP:
  - rsp_valid[gnt_idx] = 1 and rsp_data = res_q; both are held stable until rsp_ready[gnt_idx] = 1.
  - On the handshake:
    - ptr <= (gnt_idx+1) mod NUM_REQ;
    - op_count increments;
    - move to IDLE.
  - rsp_ready on non-granted indices is ignored.
- req_ready is 0 in CALC and RESP, so new requests back-pressure.
- rsp_data is a pass-through of `mul` output. Negative zero (sign 1, magnitude 0) is returned unmodified.
- Reset values: state IDLE, ptr 0, gnt_idx 0, res_q 0, rsp_valid 0, rsp_data 0, busy 0, op_count 0. req_ready is forced to 0 while rst_n is low.
- Reset mid-operation: the in-flight transaction is dropped, no response is issued, and op_count is cleared.
- Requester may drop req_valid without a handshake; nothing is latched.
- Simultaneous requests: only the one at/after ptr wins. The others wait, and each is guaranteed service within NUM_REQ transactions.

## Timing
- Request handshake at cycle T (IDLE).
- Result registered at end of T+1 (CALC).
- rsp_valid high from T+2.
- With rsp_ready already high at T+2, the FSM is in IDLE at T+3 and the next handshake may occur at T+3.
- Peak throughput: 1 operation per 3 cycles.
- Latency from request handshake to first rsp_valid: exactly 2 cycles.
- Response stall: each cycle rsp_ready is low adds 1 cycle.
- busy rises the cycle after the request handshake and falls the cycle after the response handshake.
- req_ready has a combinational path from req_valid and ptr only, with no path from rsp_ready.

## Structure
- Package mul_arb_pkg holds:
  - OP_W = 3, RES_W = 5, CNT_W = 8;
  - state enum type {IDLE, CALC, RESP};
  - a function computing the round-robin pick from (valid vector, ptr).
- One sub-module: the existing `mul`, instantiated once with registered operands op_a/op_b.
- Arbiter pick logic stays inline.

## Test plan
- **Single request, immediate accept.** Reset, then req 0 with a=3'b011, b=3'b011, rsp_ready=1.
  - req_ready[0] pulses at T.
  - rsp_valid[0] at T+2 with rsp_data=5'b01001.
  - op_count=1.
- **Sign handling.** Req 1 with a=3'b110, b=3'b001 gives rsp_data=5'b10010.
  - a=3'b100, b=3'b011 gives 5'b10000 (negative zero preserved).
- **Simultaneous requests.** Both requesters assert valid continuously after reset.
  - Grants alternate 0,1,0,1.
  - Each response lands on the correct rsp_valid index with its own operands.
- **Response back-pressure.** Hold rsp_ready[0]=0 for 4 cycles in RESP.
  - rsp_valid/rsp_data stay stable.
  - req_ready stays 0 for the other requester.
  - busy stays 1.
  - The next grant occurs one cycle after the response handshake.
- **Reset mid-CALC.** Assert rst_n=0 during CALC.
  - All outputs return to reset values immediately.
  - No rsp_valid is ever issued for the dropped request.
  - ptr returns to 0.
- **Counter wrap.** 256 completed transactions: op_count reads 0 after the 256th response handshake.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Round-robin pick lives here so the top keeps only the datapath glue.
package mul_arb_pkg;

  localparam int OP_W    = 3;
  localparam int RES_W   = 5;
  localparam int CNT_W   = 8;
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan downward so the smallest offset from ptr wins.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] v,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (v[j]) begin
          p.found = 1'b1;
          p.idx   = IDX_W'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mul_arbiter_mul.sv
// 3-bit sign-magnitude multiplier datapath.
// Negative zero passes through unmodified.
module mul
  import mul_arb_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [RES_W-1:0] y
);

  logic [3:0] mag;

  assign mag = {2'b00, a[1:0]} * {2'b00, b[1:0]};
  assign y   = {a[2] ^ b[2], mag};

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one mul among NUM_REQ requesters.
// IDLE -> CALC -> RESP, results returned over valid/ready.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [OP_W-1:0]    op_a_q, op_a_d;
  logic [OP_W-1:0]    op_b_q, op_b_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_REQ-1:0] vpad;
  pick_t              pick;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [OP_W-1:0]    sel_a;
  logic [OP_W-1:0]    sel_b;
  logic [RES_W-1:0]   mul_y;
  logic               req_hs;
  logic               rsp_hs;
  logic [IDX_W-1:0]   ptr_nxt;

  always_comb begin
    vpad               = '0;
    vpad[NUM_REQ-1:0]  = req_valid;
    pick               = rr_pick(vpad, ptr_q, NUM_REQ);
  end

  always_comb begin
    pick_oh = '0;
    gnt_oh  = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = pick.found && (pick.idx == IDX_W'(i));
      gnt_oh[i]  = (gnt_q == IDX_W'(i));
      if (pick_oh[i]) begin
        sel_a = req_a[OP_W*i +: OP_W];
        sel_b = req_b[OP_W*i +: OP_W];
      end
    end
  end

  // Grant depends only on req_valid/ptr, never on the response side.
  assign req_ready = (state_q == IDLE && rst_n) ? pick_oh : '0;
  assign rsp_valid = (state_q == RESP) ? gnt_oh : '0;
  assign rsp_data  = res_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

  assign req_hs  = |(req_valid & req_ready);
  assign rsp_hs  = (state_q == RESP) && |(rsp_ready & gnt_oh);
  assign ptr_nxt = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  mul u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .y (mul_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          gnt_d   = pick.idx;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = mul_y;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          ptr_d   = ptr_nxt;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
